// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, MRET and interrupts, then
// drives CSR write strobes, a flush pulse and a fetch redirect handshake.
module csr_trap_ctrl #(
    parameter int XLEN            = 64,
    parameter int IRQ_SYNC_STAGES = 2,
    parameter int IRQ_EN          = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            except_valid_i,
    output logic            except_ready_o,
    input  logic [XLEN-1:0] except_cause_i,
    input  logic [XLEN-1:0] except_pc_i,
    input  logic [XLEN-1:0] except_tval_i,
    input  logic            mret_valid_i,
    input  logic            int_boundary_i,
    input  logic [XLEN-1:0] int_pc_i,
    input  logic [XLEN-1:0] mip_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic            mstatus_mie_i,
    input  logic            mstatus_mpie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_mepc_we_o,
    output logic            csr_mcause_we_o,
    output logic            csr_mtval_we_o,
    output logic            csr_mstatus_we_o,
    output logic [XLEN-1:0] csr_mepc_o,
    output logic [XLEN-1:0] csr_mcause_o,
    output logic [XLEN-1:0] csr_mtval_o,
    output logic            mstatus_mie_o,
    output logic            mstatus_mpie_o,
    output logic [1:0]      mstatus_mpp_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        STATUS,
        MRET_STATUS,
        FLUSH,
        REDIRECT
    } state_t;

    state_t state_reg, state_next;

    logic [XLEN-1:0] cause_reg, pc_reg, tval_reg, target_reg;
    logic [XLEN-1:0] cause_next, pc_next, tval_next, target_next;
    logic            capture, load_target;

    // Interrupt sources packed as {MEI, MTI, MSI}.
    logic [2:0] mip_raw, mie_sel, mip_sync, pend;
    logic       irq_allow;
    logic [3:0] irq_code;
    logic [XLEN-1:0] irq_cause;

    assign mip_raw   = {mip_i[11], mip_i[7], mip_i[3]};
    assign mie_sel   = {mie_i[11], mie_i[7], mie_i[3]};
    assign irq_allow = (IRQ_EN != 0) && mstatus_mie_i;

    generate
        if (IRQ_SYNC_STAGES == 0) begin : g_sync_bypass
            assign mip_sync = mip_raw;
        end else begin : g_sync
            logic [2:0] stage_reg [IRQ_SYNC_STAGES];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < IRQ_SYNC_STAGES; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= mip_raw;
                    for (int i = 1; i < IRQ_SYNC_STAGES; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end
            assign mip_sync = stage_reg[IRQ_SYNC_STAGES-1];
        end
    endgenerate

    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
        assign pend[gi] = mip_sync[gi] & mie_sel[gi] & irq_allow;
    end

    always_comb begin
        irq_code = 4'd7;
        if (pend[2]) begin
            irq_code = 4'd11;
        end else if (pend[0]) begin
            irq_code = 4'd3;
        end
        irq_cause            = '0;
        irq_cause[XLEN-1]    = 1'b1;
        irq_cause[3:0]       = irq_code;
    end

    // Vectored mode offsets only interrupts; modes 1x fall back to direct.
    logic [XLEN-1:0] mtvec_base, vec_off, trap_target;
    assign mtvec_base  = {mtvec_i[XLEN-1:2], 2'b00};
    assign vec_off     = {cause_reg[XLEN-3:0], 2'b00};
    assign trap_target = (mtvec_i[1:0] == 2'b01 && cause_reg[XLEN-1])
                         ? mtvec_base + vec_off : mtvec_base;

    always_comb begin
        state_next       = state_reg;
        except_ready_o   = 1'b0;
        capture          = 1'b0;
        cause_next       = cause_reg;
        pc_next          = pc_reg;
        tval_next        = tval_reg;
        load_target      = 1'b0;
        target_next      = target_reg;
        csr_mepc_we_o    = 1'b0;
        csr_mcause_we_o  = 1'b0;
        csr_mtval_we_o   = 1'b0;
        csr_mstatus_we_o = 1'b0;
        csr_mepc_o       = '0;
        csr_mcause_o     = '0;
        csr_mtval_o      = '0;
        mstatus_mie_o    = 1'b0;
        mstatus_mpie_o   = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        case (state_reg)
            IDLE: begin
                except_ready_o = except_valid_i | mret_valid_i;
                if (except_valid_i) begin
                    capture    = 1'b1;
                    cause_next = except_cause_i;
                    pc_next    = except_pc_i;
                    tval_next  = except_tval_i;
                    state_next = SAVE;
                end else if (mret_valid_i) begin
                    state_next = MRET_STATUS;
                end else if (int_boundary_i && (|pend)) begin
                    capture    = 1'b1;
                    cause_next = irq_cause;
                    pc_next    = int_pc_i;
                    tval_next  = '0;
                    state_next = SAVE;
                end
            end
            SAVE: begin
                csr_mepc_we_o   = 1'b1;
                csr_mcause_we_o = 1'b1;
                csr_mtval_we_o  = 1'b1;
                csr_mepc_o      = {pc_reg[XLEN-1:2], 2'b00};
                csr_mcause_o    = cause_reg;
                csr_mtval_o     = tval_reg;
                state_next      = STATUS;
            end
            STATUS: begin
                csr_mstatus_we_o = 1'b1;
                mstatus_mpie_o   = mstatus_mie_i;
                load_target      = 1'b1;
                target_next      = trap_target;
                state_next       = FLUSH;
            end
            MRET_STATUS: begin
                csr_mstatus_we_o = 1'b1;
                mstatus_mie_o    = mstatus_mpie_i;
                mstatus_mpie_o   = 1'b1;
                load_target      = 1'b1;
                target_next      = mepc_i;
                state_next       = FLUSH;
            end
            FLUSH: begin
                flush_o    = 1'b1;
                state_next = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_reg;
                if (redirect_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            cause_reg  <= '0;
            pc_reg     <= '0;
            tval_reg   <= '0;
            target_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                cause_reg <= cause_next;
                pc_reg    <= pc_next;
                tval_reg  <= tval_next;
            end
            if (load_target) begin
                target_reg <= target_next;
            end
        end
    end

    assign mstatus_mpp_o = 2'b11;
    assign busy_o        = (state_reg != IDLE);

    logic unused_bits;
    assign unused_bits = ^{mip_i, mie_i, pc_reg[1:0]};

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: exception, vectored interrupt, priority,
// masking, MRET with redirect back-pressure, and reset mid-sequence.
module tb_csr_trap_ctrl;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            except_valid, except_ready, mret_valid, int_boundary;
    logic [XLEN-1:0] except_cause, except_pc, except_tval, int_pc;
    logic [XLEN-1:0] mip, mie, mtvec, mepc;
    logic            st_mie, st_mpie;
    logic            mepc_we, mcause_we, mtval_we, mstatus_we;
    logic [XLEN-1:0] mepc_d, mcause_d, mtval_d;
    logic            mie_new, mpie_new;
    logic [1:0]      mpp_new;
    logic            flush, redirect_valid, redirect_ready, busy;
    logic [XLEN-1:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.XLEN(XLEN), .IRQ_SYNC_STAGES(2), .IRQ_EN(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .except_valid_i(except_valid), .except_ready_o(except_ready),
        .except_cause_i(except_cause), .except_pc_i(except_pc),
        .except_tval_i(except_tval), .mret_valid_i(mret_valid),
        .int_boundary_i(int_boundary), .int_pc_i(int_pc),
        .mip_i(mip), .mie_i(mie), .mstatus_mie_i(st_mie),
        .mstatus_mpie_i(st_mpie), .mtvec_i(mtvec), .mepc_i(mepc),
        .csr_mepc_we_o(mepc_we), .csr_mcause_we_o(mcause_we),
        .csr_mtval_we_o(mtval_we), .csr_mstatus_we_o(mstatus_we),
        .csr_mepc_o(mepc_d), .csr_mcause_o(mcause_d), .csr_mtval_o(mtval_d),
        .mstatus_mie_o(mie_new), .mstatus_mpie_o(mpie_new),
        .mstatus_mpp_o(mpp_new), .flush_o(flush),
        .redirect_valid_o(redirect_valid), .redirect_ready_i(redirect_ready),
        .redirect_pc_o(redirect_pc), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int limit, output int n);
        n = 0;
        while (!busy && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic ack_redirect(input string tag);
        int n = 0;
        while (!redirect_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_rvalid"}, redirect_valid, 1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        rst_ni = 1'b0;
        except_valid = 0; mret_valid = 0; int_boundary = 0; redirect_ready = 0;
        except_cause = '0; except_pc = '0; except_tval = '0; int_pc = '0;
        mip = '0; mie = '0; mtvec = '0; mepc = '0; st_mie = 0; st_mpie = 0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_mpp", mpp_new, 2'b11);
        check("rst_ready", except_ready, 0);
        check("rst_strobes", {mepc_we, mcause_we, mtval_we, mstatus_we, flush, redirect_valid}, 0);
        rst_ni = 1'b1;
        tick();

        // Illegal instruction, direct mtvec
        $display("txn exception cause=2 pc=0x80000100");
        mtvec = 64'h8000_0000; st_mie = 1;
        except_valid = 1; except_cause = 64'd2; except_pc = 64'h8000_0100; except_tval = 64'hDEAD;
        #1;
        check("exc_ready", except_ready, 1);
        tick();
        except_valid = 0;
        check("exc_save_we", {mepc_we, mcause_we, mtval_we, mstatus_we}, 4'b1110);
        check("exc_mepc", mepc_d, 64'h8000_0100);
        check("exc_mcause", mcause_d, 64'd2);
        check("exc_mtval", mtval_d, 64'hDEAD);
        tick();
        check("exc_status_we", {mepc_we, mstatus_we}, 2'b01);
        check("exc_mpie", mpie_new, 1);
        check("exc_mie", mie_new, 0);
        check("exc_mpp", mpp_new, 2'b11);
        tick();
        check("exc_flush", flush, 1);
        check("exc_rv_early", redirect_valid, 0);
        tick();
        check("exc_rv_lat4", redirect_valid, 1);
        check("exc_flush_once", flush, 0);
        check("exc_target", redirect_pc, 64'h8000_0000);
        ack_redirect("exc");

        // Vectored machine timer interrupt through the 2-stage synchronizer
        $display("txn interrupt MTI vectored");
        mtvec = 64'h8000_0001; mie = 64'h80; int_boundary = 1; int_pc = 64'h8000_0302;
        mip = 64'h80;
        // two sync edges make it pending, the third edge accepts it
        wait_busy(10, n);
        check("mti_lat", n, 3);
        mip = '0; int_boundary = 0;
        check("mti_mcause", mcause_d, 64'h8000_0000_0000_0007);
        check("mti_mtval", mtval_d, 64'h0);
        check("mti_mepc", mepc_d, 64'h8000_0300);
        tick(); tick(); tick();
        check("mti_target", redirect_pc, 64'h8000_001C);
        ack_redirect("mti");

        // Exception beats all interrupts, then MEI beats MSI/MTI
        $display("txn priority exc then MEI");
        mie = 64'h888; mip = 64'h888; int_boundary = 1;
        except_valid = 1; except_cause = 64'd5; except_pc = 64'h8000_0400; except_tval = 64'h44;
        #1;
        check("pri_ready", except_ready, 1);
        tick();
        except_valid = 0;
        check("pri_exc_mcause", mcause_d, 64'd5);
        tick(); tick(); tick();
        check("pri_exc_target", redirect_pc, 64'h8000_0000);
        ack_redirect("pri_exc");
        tick();
        check("pri_irq_busy", busy, 1);
        check("pri_mei_mcause", mcause_d, 64'h8000_0000_0000_000B);
        mip = '0; int_boundary = 0;
        tick(); tick(); tick();
        check("pri_mei_target", redirect_pc, 64'h8000_002C);
        ack_redirect("pri_mei");

        // Global MIE masks a pending enabled interrupt
        $display("txn masking MEI with MIE=0");
        mtvec = 64'h8000_0000; st_mie = 0; mie = 64'h800; mip = 64'h800; int_boundary = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy) seen = 1;
        end
        check("mask_no_trap", seen, 0);
        st_mie = 1;
        wait_busy(5, n);
        check("mask_lat", (n >= 1 && n <= 3), 1);
        mip = '0; int_boundary = 0;
        check("mask_mcause", mcause_d, 64'h8000_0000_0000_000B);
        ack_redirect("mask");

        // MRET with redirect back-pressure
        $display("txn mret mepc=0x80000200");
        st_mie = 0; st_mpie = 1; mepc = 64'h8000_0200; mret_valid = 1;
        #1;
        check("mret_ready", except_ready, 1);
        tick();
        mret_valid = 0;
        check("mret_status_we", {mepc_we, mcause_we, mstatus_we}, 3'b001);
        check("mret_mie", mie_new, 1);
        check("mret_mpie", mpie_new, 1);
        check("mret_mpp", mpp_new, 2'b11);
        tick();
        check("mret_flush", flush, 1);
        except_valid = 1; except_cause = 64'd3;
        mepc = 64'h1234;
        #1;
        check("mret_busy_ignore", except_ready, 0);
        tick();
        except_valid = 0;
        check("mret_rv_lat3", redirect_valid, 1);
        check("mret_target", redirect_pc, 64'h8000_0200);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mret_hold_valid", redirect_valid, 1);
            check("mret_hold_pc", redirect_pc, 64'h8000_0200);
        end
        ack_redirect("mret");

        // Reset asserted while in STATUS
        $display("txn reset during STATUS");
        st_mie = 1;
        except_valid = 1; except_cause = 64'd4; except_pc = 64'h8000_0500; except_tval = 64'h1;
        tick();
        except_valid = 0;
        tick();
        check("rststat_we", mstatus_we, 1);
        rst_ni = 0;
        #1;
        check("rststat_drop", {mepc_we, mcause_we, mtval_we, mstatus_we, flush, redirect_valid}, 0);
        check("rststat_busy", busy, 0);
        tick(); tick();
        rst_ni = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy || mstatus_we || flush) seen = 1;
        end
        check("rststat_quiet", seen, 0);
        check("rststat_mcause", mcause_d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
